irrigation_scheduler: RTL

Sequencing controller around the fuzzy irrigation `rule_engine`. It requests a sensor sample and captures the three aggregated rule outputs (`irrigar_pouco`, `irrigar_medio`, `irrigar_muito`). It defuzzifies them by weighted average using a sequential restoring divider, then runs the pump for a time proportional to the result, followed by a mandatory cooldown. It sits between the sensor/fuzzification front end and the pump driver.

---
 rtl/irrigation_scheduler.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/irrigation_scheduler.sv
// Irrigation cycle sequencer: samples the fuzzy rule outputs, defuzzifies them by
// weighted average with an 18-step restoring divider, drives the pump for a time
// proportional to the result, then enforces a fixed cooldown before the next cycle.
module irrigation_scheduler #(
  parameter int unsigned W_POUCO        = 64,
  parameter int unsigned W_MEDIO        = 160,
  parameter int unsigned W_MUITO        = 255,
  parameter int unsigned TICK_DIV       = 1000,
  parameter int unsigned COOLDOWN_UNITS = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cycle_start,
  input  logic       sensor_valid,
  input  logic [7:0] irrigar_pouco,
  input  logic [7:0] irrigar_medio,
  input  logic [7:0] irrigar_muito,
  input  logic       tank_low,
  input  logic       abort,
  output logic       sensor_req,
  output logic       pump_on,
  output logic       busy,
  output logic [7:0] duty,
  output logic       duty_valid,
  output logic       fault
);

  typedef enum logic [2:0] {
    StIdle,
    StReq,
    StAccum,
    StDiv,
    StIrrigate,
    StCooldown
  } state_e;

  localparam logic [17:0] WPouco    = 18'(W_POUCO);
  localparam logic [17:0] WMedio    = 18'(W_MEDIO);
  localparam logic [17:0] WMuito    = 18'(W_MUITO);
  localparam logic [15:0] PrescMax  = 16'(TICK_DIV - 1);
  localparam logic [7:0]  CoolUnits = 8'(COOLDOWN_UNITS);
  localparam logic [4:0]  LastStep  = 5'd17;

  state_e      state_q;
  logic [7:0]  p_q, m_q, u_q;
  logic [17:0] div_q;       // holds num after ACCUM, shifts into the quotient
  logic [9:0]  den_q;
  logic [9:0]  rem_q;
  logic [4:0]  step_q;
  logic [15:0] presc_q;
  logic [7:0]  unit_q;
  logic        sensor_req_q, pump_on_q, busy_q, duty_valid_q, fault_q;
  logic [7:0]  duty_q;

  logic [17:0] num_calc;
  logic [9:0]  den_calc;
  logic [10:0] trial;
  logic        trial_ge;
  logic [9:0]  rem_next;
  logic [17:0] quo_next;
  logic [7:0]  duty_next;
  logic        presc_wrap;

  // Weighted-sum operands and one restoring-division step.
  always_comb begin
    num_calc   = 18'(p_q) * WPouco + 18'(m_q) * WMedio + 18'(u_q) * WMuito;
    den_calc   = 10'(p_q) + 10'(m_q) + 10'(u_q);
    trial      = {rem_q, div_q[17]};
    trial_ge   = trial >= {1'b0, den_q};
    // When the trial is below den it is below 1024, so the top bit is zero.
    rem_next   = trial_ge ? 10'(trial - {1'b0, den_q}) : trial[9:0];
    quo_next   = {div_q[16:0], trial_ge};
    // A zero divisor would yield an all-ones quotient; force zero duty instead.
    duty_next  = (den_q == 10'd0) ? 8'd0 : quo_next[7:0];
    presc_wrap = presc_q == PrescMax;
  end

  // Sequencer FSM with all outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      p_q          <= '0;
      m_q          <= '0;
      u_q          <= '0;
      div_q        <= '0;
      den_q        <= '0;
      rem_q        <= '0;
      step_q       <= '0;
      presc_q      <= '0;
      unit_q       <= '0;
      sensor_req_q <= 1'b0;
      pump_on_q    <= 1'b0;
      busy_q       <= 1'b0;
      duty_valid_q <= 1'b0;
      fault_q      <= 1'b0;
      duty_q       <= '0;
    end else begin
      duty_valid_q <= 1'b0;
      if (abort && (state_q != StIdle)) begin
        state_q      <= StIdle;
        sensor_req_q <= 1'b0;
        pump_on_q    <= 1'b0;
        busy_q       <= 1'b0;
        step_q       <= '0;
        presc_q      <= '0;
        unit_q       <= '0;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (cycle_start) begin
              if (tank_low) begin
                fault_q <= 1'b1;
              end else begin
                fault_q      <= 1'b0;
                state_q      <= StReq;
                sensor_req_q <= 1'b1;
                busy_q       <= 1'b1;
              end
            end
          end
          StReq: begin
            if (sensor_valid) begin
              p_q          <= irrigar_pouco;
              m_q          <= irrigar_medio;
              u_q          <= irrigar_muito;
              sensor_req_q <= 1'b0;
              state_q      <= StAccum;
            end
          end
          StAccum: begin
            div_q   <= num_calc;
            den_q   <= den_calc;
            rem_q   <= '0;
            step_q  <= '0;
            state_q <= StDiv;
          end
          StDiv: begin
            div_q  <= quo_next;
            rem_q  <= rem_next;
            step_q <= step_q + 5'd1;
            if (step_q == LastStep) begin
              step_q       <= '0;
              presc_q      <= '0;
              duty_q       <= duty_next;
              duty_valid_q <= 1'b1;
              if (duty_next != 8'd0) begin
                state_q   <= StIrrigate;
                pump_on_q <= 1'b1;
                unit_q    <= duty_next;
              end else begin
                state_q <= StCooldown;
                unit_q  <= CoolUnits;
              end
            end
          end
          StIrrigate: begin
            if (tank_low) begin
              pump_on_q <= 1'b0;
              fault_q   <= 1'b1;
              state_q   <= StCooldown;
              presc_q   <= '0;
              unit_q    <= CoolUnits;
            end else if (presc_wrap) begin
              presc_q <= '0;
              if (unit_q == 8'd1) begin
                pump_on_q <= 1'b0;
                state_q   <= StCooldown;
                unit_q    <= CoolUnits;
              end else begin
                unit_q <= unit_q - 8'd1;
              end
            end else begin
              presc_q <= presc_q + 16'd1;
            end
          end
          StCooldown: begin
            if (presc_wrap) begin
              presc_q <= '0;
              if (unit_q == 8'd1) begin
                state_q <= StIdle;
                busy_q  <= 1'b0;
                unit_q  <= '0;
              end else begin
                unit_q <= unit_q - 8'd1;
              end
            end else begin
              presc_q <= presc_q + 16'd1;
            end
          end
          default: begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign sensor_req = sensor_req_q;
  assign pump_on    = pump_on_q;
  assign busy       = busy_q;
  assign duty       = duty_q;
  assign duty_valid = duty_valid_q;
  assign fault      = fault_q;

endmodule
